cmd_queue: RTL

Circular command buffer directly upstream of the issuer. Accepts new commands from the host/dispatch side and serves the issuer's request/acknowledge port: read pops the head command, write re-queues a command the issuer found blocked by a scoreboard dependency. One issuer transaction is in flight at a time; each is completed by a one-cycle `o_ack` pulse.

---
 rtl/cmd_queue.sv | 109 ++++++++++
 1 files changed

// File: rtl/cmd_queue.sv
// Circular command buffer feeding the issuer: host pushes at the tail; the issuer pops the head or re-queues a blocked command.
// Optional macro CMDQ_WB_RESERVE_EN keeps one entry free for writebacks so the issuer can always re-queue.
module cmd_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [DATA_W-1:0] i_host_cmd,
    input  logic              i_host_valid,
    output logic              o_host_ready,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [DATA_W-1:0] i_cmd,
    output logic [DATA_W-1:0] o_cmd,
    output logic              o_ack,
    output logic              o_empty,
    output logic              o_full,
    output logic [CNT_W-1:0]  o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACK     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
`ifdef CMDQ_WB_RESERVE_EN
    localparam logic [CNT_W-1:0] HOST_LIMIT = CNT_W'(DEPTH - 1);
`else
    localparam logic [CNT_W-1:0] HOST_LIMIT = CNT_W'(DEPTH);
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] cmd_q, cmd_d;

    logic idle;
    logic pop;
    logic wb_push;
    logic wb_pending;
    logic host_ready;
    logic host_push;
    logic any_push;

    // A pending writeback (write without read) blocks the host so both never target wr_ptr on one edge.
    assign idle       = (state_q == ST_IDLE);
    assign wb_pending = idle && i_write && !i_read;
    assign pop        = idle && i_read && (count_q != '0);
    assign wb_push    = wb_pending && (count_q < FULL_CNT);
    assign host_ready = (count_q < HOST_LIMIT) && !wb_pending;
    assign host_push  = i_host_valid && host_ready;
    assign any_push   = wb_push || host_push;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (pop || wb_push) state_d = ST_ACK;
            ST_ACK:     state_d = ST_RELEASE;
            ST_RELEASE: if (!i_read && !i_write) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(any_push);
        count_d  = count_q + CNT_W'(any_push) - CNT_W'(pop);
        cmd_d    = pop ? mem_q[rd_ptr_q] : cmd_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cmd_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            cmd_q    <= cmd_d;
        end
    end

    // Entry storage carries no reset; occupancy alone defines which slots hold live commands.
    always_ff @(posedge i_clk) begin
        if (wb_push) begin
            mem_q[wr_ptr_q] <= i_cmd;
        end else if (host_push) begin
            mem_q[wr_ptr_q] <= i_host_cmd;
        end
    end

    assign o_host_ready = host_ready;
    assign o_cmd        = cmd_q;
    assign o_ack        = (state_q == ST_ACK);
    assign o_empty      = (count_q == '0);
    assign o_full       = (count_q == FULL_CNT);
    assign o_count      = count_q;

endmodule
